// File: rtl/deshifter_pkg.sv
// Shared definitions for the 20-bit LSB-first serial link receiver.
// Optional build macro: DESHIFTER_PARITY_EN appends an even-parity bit to every frame.
package deshifter_pkg;

  // Link width shared with the parallel-load shift transmitter.
  localparam int LINK_WIDTH = 20;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

`ifdef DESHIFTER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Serial bits per frame: data bits plus the optional parity bit.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/deshifter.sv
// Serial-in, parallel-out receiver for the LSB-first link.
// A start strobe marks bit 0; the word is rebuilt by right-shifting so bit 0
// ends at the LSB. The completed word is held on data_out with a one-cycle
// data_valid pulse. A start during a partial frame aborts it (frame_err).
// Optional build macro: DESHIFTER_PARITY_EN (frame carries an extra even-parity
// bit; parity_err pulses with data_valid on mismatch). Without it parity_err is 0.
module deshifter
  import deshifter_pkg::*;
#(
  parameter int WIDTH = LINK_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int              FRAME_LEN = frame_len(WIDTH);
  // Counter value of the final sample of a frame (last data bit or parity bit).
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
`ifdef DESHIFTER_PARITY_EN
  logic               perr_q, perr_d;
`endif

  // Newest sample enters at the MSB; after WIDTH samples bit 0 sits at the LSB.
  logic [WIDTH-1:0]   shifted;
  assign shifted = {serial_in, sreg_q[WIDTH-1:1]};

  // Next-state logic: a start always wins, restarting the frame from bit 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef DESHIFTER_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (start) begin
      ferr_d  = (state_q == RECV);
      state_d = RECV;
      cnt_d   = CNT_ONE;
      sreg_d  = shifted;
    end else if (state_q == RECV) begin
      if (cnt_q == LAST_CNT) begin
        valid_d = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
`ifdef DESHIFTER_PARITY_EN
        // Final sample is the parity bit; data is already fully assembled.
        dout_d  = sreg_q;
        perr_d  = ^{serial_in, sreg_q};
`else
        dout_d  = shifted;
        sreg_d  = shifted;
`endif
      end else begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CNT_ONE;
      end
    end
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef DESHIFTER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef DESHIFTER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == RECV);
  assign frame_err  = ferr_q;
`ifdef DESHIFTER_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deshifter.sv
// Self-checking bench for deshifter: directed frames, aborts, reset, loopback
// from a parallel-load shift transmitter, and random traffic, all compared
// against a bit-queue frame model.
module tb_deshifter;
  import deshifter_pkg::*;

  localparam int W  = LINK_WIDTH;
  localparam int FL = frame_len(W);

  logic         clk = 1'b0;
  logic         reset;
  logic         st_tb, ser_tb, loop_sel, tx_load;
  logic [W-1:0] tx_data;
  logic         start_w, ser_w;
  logic [W-1:0] data_out;
  logic         data_valid, busy, frame_err, parity_err;

  always #5 clk = ~clk;

  // Parallel-load shift transmitter: on load, bit 0 goes out in the same cycle.
  logic [FL-1:0] tx_frame, tx_sreg_q;
`ifdef DESHIFTER_PARITY_EN
  assign tx_frame = {^tx_data, tx_data};
`else
  assign tx_frame = tx_data;
`endif
  always_ff @(posedge clk) tx_sreg_q <= tx_load ? (tx_frame >> 1) : (tx_sreg_q >> 1);

  assign start_w = loop_sel ? tx_load : st_tb;
  assign ser_w   = loop_sel ? (tx_load ? tx_frame[0] : tx_sreg_q[0]) : ser_tb;

  deshifter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start_w),
    .serial_in  (ser_w),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // Reference model: bits of the current frame collected in a queue.
  bit           mq[$];
  bit           in_frame;
  logic [W-1:0] e_dout;
  logic         e_valid, e_busy, e_ferr, e_perr;

  int n_pass = 0, n_checks = 0, cyc = 0;
  int last_valid_cyc = -1, last_ferr_cyc = -1, n_valid = 0, n_ferr = 0;

  task automatic model_reset();
    mq.delete();
    in_frame = 1'b0;
    e_dout = '0; e_valid = 1'b0; e_busy = 1'b0; e_ferr = 1'b0; e_perr = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic d);
    logic [W-1:0] w;
    e_valid = 1'b0; e_ferr = 1'b0; e_perr = 1'b0;
    if (s) begin
      e_ferr = in_frame;
      mq.delete();
      mq.push_back(d);
      in_frame = 1'b1;
    end else if (in_frame) begin
      mq.push_back(d);
      if (mq.size() == FL) begin
        w = '0;
        for (int i = 0; i < W; i++) w[i] = mq[i];
        e_dout  = w;
        e_valid = 1'b1;
`ifdef DESHIFTER_PARITY_EN
        begin
          logic p;
          p = 1'b0;
          foreach (mq[i]) p ^= mq[i];
          e_perr = p;
        end
`endif
        in_frame = 1'b0;
        mq.delete();
      end
    end
    e_busy = in_frame;
  endtask

  task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, obs, exp_v);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s cyc=%0d: got %b, expected %b", tag, cyc, obs, exp_v);
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs == exp_v) n_pass++;
    else $error("FAIL %s cyc=%0d: got %0d, expected %0d", tag, cyc, obs, exp_v);
  endtask

  // One clock: capture inputs mid-cycle, advance model at the edge, compare after it.
  task automatic cycle();
    logic s, d;
    @(negedge clk);
    s = start_w;
    d = ser_w;
    @(posedge clk);
    cyc++;
    model_edge(s, d);
    #1;
    if (data_valid === 1'b1) begin last_valid_cyc = cyc; n_valid++; end
    if (frame_err === 1'b1) begin last_ferr_cyc = cyc; n_ferr++; end
    chk_w("data_out",   data_out,   e_dout);
    chk_b("data_valid", data_valid, e_valid);
    chk_b("busy",       busy,       e_busy);
    chk_b("frame_err",  frame_err,  e_ferr);
    chk_b("parity_err", parity_err, e_perr);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic pbit);
    for (int i = 0; i < FL; i++) begin
      st_tb  = (i == 0);
      ser_tb = (i < W) ? word[i] : pbit;
      cycle();
    end
    st_tb = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      st_tb  = 1'b0;
      ser_tb = 1'($urandom_range(0, 1));
      cycle();
    end
  endtask

  int s0, nv, nf;
  logic [W-1:0] wv;

  initial begin
    reset = 1'b1; st_tb = 1'b0; ser_tb = 1'b0;
    loop_sel = 1'b0; tx_load = 1'b0; tx_data = '0;
    model_reset();

    // Reset state
    #12;
    chk_w("rst_data_out", data_out, '0);
    chk_b("rst_valid",    data_valid, 1'b0);
    chk_b("rst_busy",     busy, 1'b0);
    chk_b("rst_ferr",     frame_err, 1'b0);
    chk_b("rst_perr",     parity_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(3);

    // Basic frame
    wv = 20'hA5C3E;
    s0 = cyc;
    send_frame(wv, ^wv);
    chk_i("basic_latency", last_valid_cyc - s0, FL);
    chk_w("basic_word", data_out, 20'hA5C3E);
    idle_cycles(6);
    chk_w("basic_hold", data_out, 20'hA5C3E);

    // Back-to-back frames with zero gap
    s0 = cyc; nv = n_valid;
    wv = 20'h00001;
    send_frame(wv, ^wv);
    chk_i("b2b_first_cyc", last_valid_cyc - s0, FL);
    chk_w("b2b_first_word", data_out, 20'h00001);
    wv = 20'hFFFFF;
    send_frame(wv, ^wv);
    chk_i("b2b_second_cyc", last_valid_cyc - s0, 2 * FL);
    chk_w("b2b_second_word", data_out, 20'hFFFFF);
    chk_i("b2b_valid_count", n_valid - nv, 2);
    idle_cycles(2);

    // Abort: new start in cycle 7
    s0 = cyc; nv = n_valid;
    for (int i = 0; i < 7; i++) begin
      st_tb = (i == 0);
      ser_tb = 1'($urandom_range(0, 1));
      cycle();
    end
    wv = 20'h12345;
    send_frame(wv, ^wv);
    chk_i("abort_ferr_cyc", last_ferr_cyc - s0, 8);
    chk_i("abort_valid_cyc", last_valid_cyc - s0, 7 + FL);
    chk_i("abort_valid_count", n_valid - nv, 1);
    chk_w("abort_word", data_out, 20'h12345);
    idle_cycles(2);

    // Start held high for three cycles
    nf = n_ferr;
    for (int i = 0; i < 3; i++) begin
      st_tb = 1'b1;
      ser_tb = 1'($urandom_range(0, 1));
      cycle();
    end
    idle_cycles(FL + 1);
    chk_i("held_start_ferr", n_ferr - nf, 2);

    // Abort on the final sample of a frame
    nv = n_valid;
    st_tb = 1'b1; ser_tb = 1'b1; cycle();
    for (int i = 1; i < FL - 1; i++) begin st_tb = 1'b0; ser_tb = 1'b0; cycle(); end
    wv = 20'h0BEEF;
    send_frame(wv, ^wv);
    chk_i("late_abort_valid_count", n_valid - nv, 1);
    chk_w("late_abort_word", data_out, 20'h0BEEF);
    idle_cycles(2);

    // Reset in the middle of a frame
    st_tb = 1'b1; ser_tb = 1'b1; cycle();
    for (int i = 1; i < 10; i++) begin st_tb = 1'b0; ser_tb = 1'b1; cycle(); end
    #2;
    reset = 1'b1;
    #1;
    chk_w("rst_mid_data_out", data_out, '0);
    chk_b("rst_mid_valid",    data_valid, 1'b0);
    chk_b("rst_mid_busy",     busy, 1'b0);
    chk_b("rst_mid_ferr",     frame_err, 1'b0);
    chk_b("rst_mid_perr",     parity_err, 1'b0);
    model_reset();
    @(posedge clk); cyc++; #1;
    reset = 1'b0;
    nv = n_valid;
    idle_cycles(25);
    chk_i("rst_no_valid", n_valid - nv, 0);
    wv = 20'h0F0F0;
    send_frame(wv, ^wv);
    chk_w("rst_next_word", data_out, 20'h0F0F0);
    idle_cycles(2);

    // Loopback from the transmitter
    loop_sel = 1'b1;
    tx_data  = 20'h5A5A5;
    tx_load  = 1'b1;
    s0 = cyc;
    cycle();
    tx_load = 1'b0;
    for (int i = 1; i < FL; i++) cycle();
    loop_sel = 1'b0;
    chk_i("loop_latency", last_valid_cyc - s0, FL);
    chk_w("loop_word", data_out, 20'h5A5A5);
    chk_b("loop_parity_ok", parity_err, 1'b0);
    idle_cycles(2);

`ifdef DESHIFTER_PARITY_EN
    // Parity checking
    s0 = cyc;
    send_frame(20'h00003, 1'b1);
    chk_i("par_latency", last_valid_cyc - s0, W + 1);
    chk_b("par_err_set", parity_err, 1'b1);
    chk_w("par_word", data_out, 20'h00003);
    send_frame(20'h00003, 1'b0);
    chk_b("par_err_clear", parity_err, 1'b0);
    idle_cycles(2);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      st_tb  = ($urandom_range(0, 11) == 0);
      ser_tb = 1'($urandom_range(0, 1));
      cycle();
    end
    idle_cycles(FL + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/deshifter.md
Name: deshifter

Overview:
- Serial-in, parallel-out receiver; the receive end of the 20-bit LSB-first serial link driven by the team's parallel-load shift transmitter.
- Samples one bit per clock, starting at a frame-start strobe, and reassembles the WIDTH-bit word.
- Presents the word on a held parallel output with a one-cycle valid pulse.
- Flags aborted frames and, optionally, parity errors.

Parameters:
- WIDTH, 20: data bits per frame; legal range 2..64.
- CNT_W, 5: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  frame-start strobe; high in the same cycle that serial_in carries bit 0.
- serial_in  input  1  serial data, LSB first, one bit per clock.
- data_out  output  WIDTH  last completed word; held until the next completed frame.
- data_valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high while a frame is partially received.
- frame_err  output  1  one-cycle pulse when a partial frame is aborted by a new start.
- parity_err  output  1  one-cycle pulse with data_valid on parity mismatch; constant 0 without DESHIFTER_PARITY_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, bit counter=0, shift register=0.
  - data_out=0, data_valid=0, busy=0, frame_err=0, parity_err=0.
- States: IDLE, RECV. busy = (state==RECV), registered.
- IDLE:
  - start=1: sample serial_in as bit 0, counter<=1, go to RECV.
  - start=0: hold; serial_in ignored.
- RECV, start=0:
  - Shift register <= {serial_in, sreg[WIDTH-1:1]}, i.e. right-shift, so bit 0 lands at LSB after WIDTH samples.
  - Counter increments.
- Last bit: when the sample taken is bit WIDTH-1 (counter==WIDTH-1), on that edge:
  - data_out <= fully assembled word.
  - data_valid <= 1 for exactly one cycle.
  - state <= IDLE, counter <= 0.
- Latency: start in cycle 0 gives data_valid and new data_out in cycle WIDTH (20 for the default).
- Back-to-back frames: start may be asserted in the cycle data_valid is high (cycle WIDTH). It is accepted with zero gap, so sustained throughput is one word per WIDTH cycles.
- start while in RECV (including the cycle carrying bit WIDTH-1):
  - start has priority: the partial frame is discarded and data_out is not updated.
  - frame_err pulses for one cycle; serial_in in that cycle is taken as bit 0 of a new frame; counter<=1; remains in RECV.
- data_out holds its value indefinitely between frames; data_valid is never high for two consecutive cycles.
- Reset mid-frame: partial data is lost immediately and all outputs clear asynchronously. The next frame requires a new start after reset deasserts.
- start held high for several cycles: each cycle in RECV counts as a restart, so every cycle after the first pulses frame_err.

Optional Feature:
- Macro: DESHIFTER_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits; bit WIDTH is even parity over the data bits, so XOR of all WIDTH+1 bits must be 0.
  - Completion moves to the parity-bit sample; data_valid appears in cycle WIDTH+1.
  - parity_err pulses with data_valid on mismatch; data_out still updates.
  - The restart/abort rules extend to the parity-bit cycle.
- Not defined:
  - Frame is WIDTH bits, as above; parity_err tied 0.
  - No parity logic is synthesised.

Decomposition:
- Shared package holds:
  - the default link width constant (20), shared with the transmitter;
  - the IDLE/RECV state encoding;
  - the frame-length constant derived from WIDTH and the macro.
- No sub-module; the counter and shift register are inline.
- The bench instantiates the existing transmitter as stimulus source (same package width).

Test Plan:
- Basic frame: start in cycle 0, serial 20'hA5C3E LSB first -> data_valid in cycle 20 only; data_out=20'hA5C3E; busy high cycles 1-19.
- Back-to-back: 20'h00001 then 20'hFFFFF with the second start in cycle 20 -> valid in cycles 20 and 40; data_out 20'h00001 then 20'hFFFFF.
- Abort: start in cycle 0, second start in cycle 7 with 20'h12345 -> frame_err pulse in cycle 8; valid only in cycle 27; data_out=20'h12345.
- Reset mid-frame: reset pulsed in cycle 10 -> all outputs 0 asynchronously; no valid follows until a new start; next frame 20'h0F0F0 is received correctly.
- Loopback with transmitter: load 20'h5A5A5 into the transmitter, drive its load strobe as start -> data_out=20'h5A5A5 after 20 cycles.
- Parity, with DESHIFTER_PARITY_EN: word 20'h00003 with parity bit 1 -> valid in cycle 21, parity_err=1; parity bit 0 -> parity_err=0.
